// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered mem -> core -> periph reset release with sw/watchdog retrigger and cause capture
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sw_rst_req,
  output logic       o_sw_rst_ack,
  input  logic       i_wdt_expire,
  output logic       o_mem_rst,
  output logic       o_core_rst,
  output logic       o_periph_rst,
  output logic       o_ready,
  output logic [1:0] o_rst_cause
);
  typedef enum logic [1:0] {ASSERT, REL_MEM, REL_CORE, RUN} state_t;
  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(STAGE_GAP - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ASSERT;
      cnt          <= '0;
      o_mem_rst    <= 1'b1;
      o_core_rst   <= 1'b1;
      o_periph_rst <= 1'b1;
      o_ready      <= 1'b0;
      o_sw_rst_ack <= 1'b0;
      o_rst_cause  <= 2'b01;
    end else begin
      o_sw_rst_ack <= 1'b0;
      case (state)
        ASSERT:
          if (cnt == HOLD_T) begin
            state     <= REL_MEM;
            cnt       <= '0;
            o_mem_rst <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        REL_MEM:
          if (cnt == GAP_T) begin
            state      <= REL_CORE;
            cnt        <= '0;
            o_core_rst <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        REL_CORE:
          if (cnt == GAP_T) begin
            state        <= RUN;
            cnt          <= '0;
            o_periph_rst <= 1'b0;
            o_ready      <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        default:
          if (i_sw_rst_req || i_wdt_expire) begin
            state        <= ASSERT;
            cnt          <= '0;
            o_mem_rst    <= 1'b1;
            o_core_rst   <= 1'b1;
            o_periph_rst <= 1'b1;
            o_ready      <= 1'b0;
            o_sw_rst_ack <= i_sw_rst_req;
            o_rst_cause  <= i_wdt_expire ? 2'b11 : 2'b10;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release timeline, soft triggers, async reset and retrigger loop
module tb_reset_sequencer;
  logic       i_clk = 1'b0;
  logic       i_rst, i_sw_rst_req, i_wdt_expire;
  logic       o_sw_rst_ack, o_mem_rst, o_core_rst, o_periph_rst, o_ready;
  logic [1:0] o_rst_cause;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 i_clk = ~i_clk;
  reset_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sw_rst_req(i_sw_rst_req), .o_sw_rst_ack(o_sw_rst_ack),
    .i_wdt_expire(i_wdt_expire), .o_mem_rst(o_mem_rst), .o_core_rst(o_core_rst),
    .o_periph_rst(o_periph_rst), .o_ready(o_ready), .o_rst_cause(o_rst_cause)
  );
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input int k, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d: got %0d expected %0d", tag, k, got, exp);
    end
  endtask
  task automatic all_asserted(input string tag, input logic [1:0] cause, input logic ack);
    chk({tag, "_mem"}, -1, o_mem_rst, 1);
    chk({tag, "_core"}, -1, o_core_rst, 1);
    chk({tag, "_periph"}, -1, o_periph_rst, 1);
    chk({tag, "_ready"}, -1, o_ready, 0);
    chk({tag, "_ack"}, -1, o_sw_rst_ack, ack);
    chk({tag, "_cause"}, -1, o_rst_cause, cause);
  endtask
  task automatic timeline(input logic [1:0] cause, input int wlo, input int whi, input int last);
    for (int k = 0; k <= last; k++) begin
      i_wdt_expire = (k >= wlo && k <= whi);
      tick();
      chk("mem", k, o_mem_rst, k < 16);
      chk("core", k, o_core_rst, k < 20);
      chk("periph", k, o_periph_rst, k < 24);
      chk("ready", k, o_ready, k >= 24);
      chk("ack", k, o_sw_rst_ack, 0);
      chk("cause", k, o_rst_cause, cause);
    end
    i_wdt_expire = 1'b0;
  endtask
  initial begin
    i_rst = 1'b0; i_sw_rst_req = 1'b0; i_wdt_expire = 1'b0;
    #1 i_rst = 1'b1;
    repeat (3) tick();
    all_asserted("rst", 2'b01, 1'b0);
    @(negedge i_clk) i_rst = 1'b0;
    timeline(2'b01, -1, -1, 24);
    tick();
    chk("run_hold", 0, o_ready, 1);
    i_sw_rst_req = 1'b1;
    tick();
    all_asserted("sw", 2'b10, 1'b1);
    i_sw_rst_req = 1'b0;
    timeline(2'b10, 17, 22, 24);
    i_sw_rst_req = 1'b1; i_wdt_expire = 1'b1;
    tick();
    all_asserted("both", 2'b11, 1'b1);
    i_sw_rst_req = 1'b0; i_wdt_expire = 1'b0;
    timeline(2'b11, -1, -1, 24);
    i_sw_rst_req = 1'b1;
    tick();
    all_asserted("sw2", 2'b10, 1'b1);
    i_sw_rst_req = 1'b0;
    timeline(2'b10, -1, -1, 21);
    #2 i_rst = 1'b1;
    #1 all_asserted("async", 2'b01, 1'b0);
    #1 i_rst = 1'b0;
    timeline(2'b01, -1, -1, 24);
    i_sw_rst_req = 1'b1;
    repeat (2) begin
      tick();
      all_asserted("loop", 2'b10, 1'b1);
      timeline(2'b10, -1, -1, 24);
    end
    tick();
    all_asserted("loop_end", 2'b10, 1'b1);
    i_sw_rst_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates the design's reset outputs from one clean reset input, plus software and watchdog reset requests.
- Releases memory, core (PC/regfile) and peripheral resets in a fixed order, with programmable hold and gap times.
- Records the cause of the last reset and flags when the system is running.
- Its outputs feed the per-domain async-assert/sync-deassert reset synchronizers.

Parameters:
- HOLD_CYCLES, 16: cycles all resets stay asserted after the trigger is removed; must be >= 1.
- STAGE_GAP, 4: cycles between successive stage releases; must be >= 1.
- CNT_W, 8: counter width; must hold max(HOLD_CYCLES, STAGE_GAP).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset; already synchronized for deassertion upstream.
- i_sw_rst_req  input  1  software reset request, level; held until acked.
- o_sw_rst_ack  output  1  one-cycle pulse when the software request is accepted.
- i_wdt_expire  input  1  watchdog expiry, sampled level.
- o_mem_rst  output  1  memory reset, active-high, released first.
- o_core_rst  output  1  core/PC reset, active-high, released second.
- o_periph_rst  output  1  peripheral reset, active-high, released last.
- o_ready  output  1  high only in RUN.
- o_rst_cause  output  2  cause of last reset: 01 external, 10 software, 11 watchdog; 00 unused.

Behaviour:
- Reset is asynchronous and active-high. While i_rst=1:
  - state=ASSERT, counter=0.
  - o_mem_rst=o_core_rst=o_periph_rst=1.
  - o_ready=0, o_sw_rst_ack=0, o_rst_cause=01.
  - This applies immediately, even mid-sequence or in RUN.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - ASSERT: count to HOLD_CYCLES, then go to REL_MEM and clear counter.
  - REL_MEM: o_mem_rst=0; count STAGE_GAP, then go to REL_CORE.
  - REL_CORE: o_core_rst=0; count STAGE_GAP, then go to RUN.
  - RUN: o_periph_rst=0, o_ready=1.
- External timing, edge 0 = first rising edge with i_rst=0:
  - o_mem_rst falls after edge HOLD_CYCLES.
  - o_core_rst falls after edge HOLD_CYCLES+STAGE_GAP.
  - o_periph_rst and o_ready change after edge HOLD_CYCLES+2*STAGE_GAP.
- Soft triggers, accepted only in RUN, at trigger edge E:
  - All three resets go to 1 and o_ready goes to 0 after E.
  - state=ASSERT, counter=0.
  - The same release timeline then applies with edge 0 = E+1.
- Software trigger: i_sw_rst_req=1 in RUN. Set o_sw_rst_ack=1 for the single cycle after E and set o_rst_cause=10.
- Watchdog trigger: i_wdt_expire=1 in RUN. Set o_rst_cause=11; no ack.
- Both triggers in the same cycle: watchdog wins (cause=11), but the sw request is still acked. A req still high after the sequence completes is treated as a new request.
- Triggers outside RUN (ASSERT/REL_*) are ignored: no ack, no cause change, no timeline restart.
- o_rst_cause holds its value until the next trigger; i_rst forces 01.
- Counter saturates at its terminal value; no wrap-around.
- Invariant: reset release order is always mem -> core -> periph, and deassertion is never simultaneous (STAGE_GAP >= 1).

Test Plan (defaults 16/4):
- Release i_rst before edge 0 -> mem_rst falls after edge 16, core_rst after 20, periph_rst and ready after 24; cause=01; ack stays 0.
- In RUN, hold i_sw_rst_req=1 at edge E=100 -> all resets high and ready=0 after 100; ack=1 for cycle 101 only; cause=10; mem falls after edge 117, periph after 125.
- In RUN, assert i_wdt_expire and i_sw_rst_req on the same edge -> cause=11, ack pulses once, sequence restarts.
- Assert i_wdt_expire during REL_MEM -> ignored; release timing and cause unchanged.
- Pulse i_rst high mid-REL_CORE (between clock edges) -> all resets high immediately; cause=01; full 16/4/4 timeline restarts from the next edge 0.
- Hold i_sw_rst_req high continuously -> a reset cycle repeats every 26 edges (trigger + 25); ack once per cycle; o_ready high for exactly one cycle each iteration.
